recip_scale: RTL and testbench

Downstream consumer of the `reciprocal` stage. It joins each 16-bit reciprocal word with a matching signed numerator word from a parallel stream and multiplies them. The product is rounded and saturated to a 16-bit signed quotient. It is a 3-stage elastic pipeline with req/ack handshakes on all streams and a saturation event counter for debug and verification.

---
 rtl/recip_scale_if.sv | 20 ++
 rtl/recip_scale.sv | 63 ++++++
 tb/tb_recip_scale.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/recip_scale_if.sv
// recip_scale_if: numerator, reciprocal and quotient req/ack streams of recip_scale
interface recip_scale_if;
  logic [15:0] t_num_dat;
  logic [15:0] t_rcp_dat;
  logic [15:0] i_quo_dat;
  logic        t_num_req;
  logic        t_num_ack;
  logic        t_rcp_req;
  logic        t_rcp_ack;
  logic        i_quo_req;
  logic        i_quo_ack;
  modport slave (
    input  t_num_dat, t_num_req, t_rcp_dat, t_rcp_req, i_quo_ack,
    output t_num_ack, t_rcp_ack, i_quo_dat, i_quo_req
  );
  modport master (
    output t_num_dat, t_num_req, t_rcp_dat, t_rcp_req, i_quo_ack,
    input  t_num_ack, t_rcp_ack, i_quo_dat, i_quo_req
  );
endinterface

// File: rtl/recip_scale.sv
// recip_scale: joins numerator and reciprocal streams, multiplies, rounds half-up and saturates to a signed quotient
module recip_scale #(
  parameter int FRAC_RCP = 15,
  parameter int FRAC_NUM = 15
) (
  input  logic         i_clk,
  input  logic         i_rst_p,
  recip_scale_if.slave bus,
  output logic [15:0]  o_sat_cnt
);
  // product carries FRAC_NUM+FRAC_RCP fraction bits, quotient keeps FRAC_NUM
  localparam int SH = FRAC_NUM + FRAC_RCP - FRAC_NUM;
  localparam logic signed [32:0] RND = 33'sd1 <<< (SH - 1);
  logic               s1_v_q, s2_v_q, s3_v_q;
  logic signed [16:0] s1_num_q, s1_rcp_q;
  logic signed [32:0] s2_p_q, p_d, r_d;
  logic [15:0]        s3_dat_q, quo_d, sat_cnt_q, sat_cnt_d;
  logic               s1_rdy, s2_rdy, s3_rdy, xfer, hi_d, lo_d;
  always_comb begin
    s3_rdy = !s3_v_q || bus.i_quo_ack;
    s2_rdy = !s2_v_q || s3_rdy;
    s1_rdy = !s1_v_q || s2_rdy;
    xfer = bus.t_num_req && bus.t_rcp_req && s1_rdy && !i_rst_p;
    p_d = 33'(s1_num_q) * 33'(s1_rcp_q);
    r_d = (s2_p_q + RND) >>> SH;
    hi_d = r_d > 33'sd32767;
    lo_d = r_d < -33'sd32768;
    quo_d = hi_d ? 16'h7fff : lo_d ? 16'h8000 : r_d[15:0];
    sat_cnt_d = s3_rdy && s2_v_q && (hi_d || lo_d) && sat_cnt_q != 16'hffff ? sat_cnt_q + 16'd1 : sat_cnt_q;
  end
  always_ff @(posedge i_clk or posedge i_rst_p) begin
    if (i_rst_p) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s3_v_q <= 1'b0;
      s1_num_q <= '0;
      s1_rcp_q <= '0;
      s2_p_q <= '0;
      s3_dat_q <= '0;
      sat_cnt_q <= '0;
    end else begin
      if (s1_rdy) begin
        s1_v_q <= xfer;
        s1_num_q <= {bus.t_num_dat[15], bus.t_num_dat};
        s1_rcp_q <= {1'b0, bus.t_rcp_dat};
      end
      if (s2_rdy) begin
        s2_v_q <= s1_v_q;
        s2_p_q <= p_d;
      end
      if (s3_rdy) begin
        s3_v_q <= s2_v_q;
        if (s2_v_q) s3_dat_q <= quo_d;
      end
      sat_cnt_q <= sat_cnt_d;
    end
  end
  assign bus.t_num_ack = xfer;
  assign bus.t_rcp_ack = xfer;
  assign bus.i_quo_dat = s3_dat_q;
  assign bus.i_quo_req = s3_v_q;
  assign o_sat_cnt = sat_cnt_q;
endmodule

// File: tb/tb_recip_scale.sv
// tb_recip_scale: random and directed stimulus checked against a real-arithmetic quotient model
module tb_recip_scale;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] sat_cnt;
  recip_scale_if bus ();
  recip_scale #(.FRAC_RCP(15), .FRAC_NUM(15)) dut (
    .i_clk(clk), .i_rst_p(rst), .bus(bus), .o_sat_cnt(sat_cnt)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int n_out = 0, n_xfer = 0, exp_sat = 0;
  bit mon_en = 0, prev_stall = 0, bp_done = 0;
  logic [15:0] prev_dat;
  logic exp_ack;
  logic [15:0] exp_q[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [16:0] ref_quo(input logic [15:0] n, input logic [15:0] r);
    real y;
    y = $floor(real'($signed(n)) * real'(r) / 32768.0 + 0.5);
    if (y > 32767.0) return {1'b1, 16'h7fff};
    if (y < -32768.0) return {1'b1, 16'h8000};
    return {1'b0, 16'($rtoi(y))};
  endfunction
  always @(negedge clk) if (mon_en) begin
    exp_ack = bus.t_num_req && bus.t_rcp_req && (exp_q.size() < 3 || bus.i_quo_ack);
    chk("num_ack", bus.t_num_ack, exp_ack);
    chk("rcp_ack", bus.t_rcp_ack, exp_ack);
    if (prev_stall) begin
      chk("stall_req", bus.i_quo_req, 1);
      chk("stall_dat", bus.i_quo_dat, prev_dat);
    end
    prev_stall = bus.i_quo_req && !bus.i_quo_ack;
    prev_dat = bus.i_quo_dat;
    if (bus.i_quo_req && bus.i_quo_ack) begin
      chk("q_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("quo", bus.i_quo_dat, exp_q.pop_front());
      n_out++;
    end
    if (bus.t_num_ack) begin
      logic [16:0] m;
      m = ref_quo(bus.t_num_dat, bus.t_rcp_dat);
      exp_q.push_back(m[15:0]);
      if (m[16]) exp_sat++;
      n_xfer++;
    end
  end
  task automatic send(input logic [15:0] n, input logic [15:0] r);
    bit ok = 0;
    bus.t_num_dat = n;
    bus.t_rcp_dat = r;
    bus.t_num_req = 1'b1;
    bus.t_rcp_req = 1'b1;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      ok = bus.t_num_ack;
      @(posedge clk);
      #1;
    end
    bus.t_num_req = 1'b0;
    bus.t_rcp_req = 1'b0;
    chk("send_timeout", ok, 1);
  endtask
  task automatic expect_one(input string tag, input logic [15:0] n, input logic [15:0] r, input logic [15:0] e);
    send(n, r);
    @(negedge clk);
    chk("lat0", bus.i_quo_req, 0);
    @(negedge clk);
    chk("lat1", bus.i_quo_req, 0);
    @(negedge clk);
    chk("lat2", bus.i_quo_req, 1);
    chk(tag, bus.i_quo_dat, e);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
  initial begin
    int b, x;
    rst = 1'b1;
    bus.t_num_dat = '0;
    bus.t_rcp_dat = '0;
    bus.t_num_req = 1'b1;
    bus.t_rcp_req = 1'b1;
    bus.i_quo_ack = 1'b1;
    #2;
    chk("rst_req", bus.i_quo_req, 0);
    chk("rst_dat", bus.i_quo_dat, 0);
    chk("rst_sat", sat_cnt, 0);
    chk("rst_ack", {bus.t_num_ack, bus.t_rcp_ack}, 0);
    bus.t_num_req = 1'b0;
    bus.t_rcp_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    mon_en = 1;
    @(posedge clk);
    #1;
    expect_one("basic", 16'h4000, 16'h8000, 16'h4000);
    chk("sat_zero", sat_cnt, 0);
    expect_one("rnd_half_pos", 16'h0001, 16'h4000, 16'h0001);
    expect_one("rnd_half_neg", 16'hffff, 16'h4000, 16'h0000);
    expect_one("rnd_075", 16'h0003, 16'h2000, 16'h0001);
    expect_one("sat_hi", 16'h7fff, 16'hffff, 16'h7fff);
    expect_one("sat_lo", 16'h8000, 16'hffff, 16'h8000);
    chk("sat_two", sat_cnt, 2);
    b = n_out;
    x = n_xfer;
    bus.t_rcp_dat = 16'h1234;
    bus.t_rcp_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("skew_rcp_ack", bus.t_rcp_ack, 0);
      chk("skew_num_ack", bus.t_num_ack, 0);
      @(posedge clk);
      #1;
    end
    chk("skew_no_out", n_out - b, 0);
    send(16'hc000, 16'h1234);
    repeat (6) @(posedge clk);
    #1;
    chk("skew_xfer", n_xfer - x, 1);
    chk("skew_out", n_out - b, 1);
    b = n_out;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          send(16'($urandom), ($urandom_range(0, 3) == 0) ? 16'hffff : 16'($urandom));
        end
        bp_done = 1;
      end
      begin
        for (int c = 0; !bp_done; c++) begin
          @(posedge clk);
          #1;
          bus.i_quo_ack = (c % 160 >= 100 && c % 160 < 140) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.i_quo_ack = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    chk("bp_drain", exp_q.size(), 0);
    chk("bp_count", n_out - b, 1000);
    chk("bp_sat_cnt", sat_cnt, exp_sat);
    bus.i_quo_ack = 1'b0;
    send(16'h1000, 16'h8000);
    send(16'h7000, 16'hf000);
    send(16'h9000, 16'hf000);
    bus.t_num_dat = 16'h0100;
    bus.t_rcp_dat = 16'h0100;
    bus.t_num_req = 1'b1;
    bus.t_rcp_req = 1'b1;
    @(negedge clk);
    chk("full_ack", bus.t_num_ack, 0);
    #2;
    mon_en = 0;
    rst = 1'b1;
    #1;
    chk("arst_req", bus.i_quo_req, 0);
    chk("arst_dat", bus.i_quo_dat, 0);
    chk("arst_sat", sat_cnt, 0);
    chk("arst_ack", {bus.t_num_ack, bus.t_rcp_ack}, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.t_num_req = 1'b0;
    bus.t_rcp_req = 1'b0;
    bus.i_quo_ack = 1'b1;
    exp_q.delete();
    prev_stall = 0;
    exp_sat = 0;
    mon_en = 1;
    b = n_out;
    repeat (8) @(posedge clk);
    #1;
    chk("no_stale", n_out - b, 0);
    expect_one("post_rst", 16'h2000, 16'h4000, 16'h1000);
    chk("post_rst_sat", sat_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
